// File: rtl/fifo_credit_based_vc.sv
// Multi-VC input buffer for the credit-based router: one first-word-fall-through queue
// per virtual channel, per-VC credit return, and sticky overflow / packet-framing flags.
module fifo_credit_based_vc #(
  parameter int  DATA_WIDTH = 32,
  parameter int  FIFO_DEPTH = 4,
  parameter int  NUM_VC     = 2,
  parameter int  NUM_OUT    = 5,
  localparam int VCW        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        RX,
  input  logic                         valid_in,
  input  logic [VCW-1:0]               vc_in,
  input  logic [NUM_VC*NUM_OUT-1:0]    read_en,
  output logic [NUM_VC-1:0]            credit_out,
  output logic [NUM_VC-1:0]            empty_out,
  output logic [NUM_VC-1:0]            full_out,
  output logic [NUM_VC*DATA_WIDTH-1:0] Data_out,
  output logic [NUM_VC-1:0]            overflow_err,
  output logic [NUM_VC-1:0]            pkt_err
);

  localparam int              PTRW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CNTW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTRW-1:0] PTR_LAST    = PTRW'(FIFO_DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL    = CNTW'(FIFO_DEPTH);
  localparam logic [2:0]      FLIT_HEADER = 3'b001;
  localparam logic [2:0]      FLIT_BODY   = 3'b010;
  localparam logic [2:0]      FLIT_TAIL   = 3'b100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_t;

  // Pointers wrap explicitly so depths that are not powers of two work.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] ptr);
    logic [PTRW-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTRW'(1);
    end
    return nxt;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem    [NUM_VC][FIFO_DEPTH];
  logic [PTRW-1:0]       r_rd_ptr [NUM_VC];
  logic [PTRW-1:0]       r_wr_ptr [NUM_VC];
  logic [CNTW-1:0]       r_count  [NUM_VC];
  frame_state_t          r_state  [NUM_VC];
  frame_state_t          w_state_nxt [NUM_VC];
  logic [NUM_VC-1:0]     r_credit;
  logic [NUM_VC-1:0]     r_ovf;
  logic [NUM_VC-1:0]     r_pkt;

  logic [NUM_VC-1:0]     w_empty;
  logic [NUM_VC-1:0]     w_full;
  logic [NUM_VC-1:0]     w_pop;
  logic [NUM_VC-1:0]     w_wr_sel;
  logic [NUM_VC-1:0]     w_push;
  logic [NUM_VC-1:0]     w_drop;
  logic [NUM_VC-1:0]     w_frame_err;
  logic                  w_vc_ok;
  logic [2:0]            w_flit_type;

  assign w_flit_type = RX[DATA_WIDTH-1 -: 3];
  assign w_vc_ok     = ({1'b0, vc_in} < (VCW + 1)'(NUM_VC));

  // Queue status decoded from the registered occupancy.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_empty[v] = (r_count[v] == '0);
      w_full[v]  = (r_count[v] == CNT_FULL);
    end
  end

  // Pop requests (any arbiter) and write steering.
  always_comb begin
    w_pop    = '0;
    w_wr_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_pop[v]    = (|read_en[v*NUM_OUT +: NUM_OUT]) & ~w_empty[v];
      w_wr_sel[v] = valid_in & w_vc_ok & (vc_in == VCW'(v));
    end
  end

  // A full VC still takes a write when the same VC pops this cycle.
  always_comb begin
    w_push = '0;
    w_drop = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_push[v] = w_wr_sel[v] & (~w_full[v] | w_pop[v]);
      w_drop[v] = w_wr_sel[v] & w_full[v] & ~w_pop[v];
    end
  end

  // Framing next-state and violation detection, advanced only by accepted writes.
  always_comb begin
    w_frame_err = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_state_nxt[v] = r_state[v];
      if (w_push[v]) begin
        case (w_flit_type)
          FLIT_HEADER: begin
            if (r_state[v] == ST_IDLE) begin
              w_state_nxt[v] = ST_IN_PKT;
            end else begin
              w_frame_err[v] = 1'b1;
            end
          end
          FLIT_BODY: begin
            if (r_state[v] == ST_IDLE) begin
              w_frame_err[v] = 1'b1;
            end else begin
              w_state_nxt[v] = ST_IN_PKT;
            end
          end
          FLIT_TAIL: begin
            if (r_state[v] == ST_IN_PKT) begin
              w_state_nxt[v] = ST_IDLE;
            end else begin
              w_frame_err[v] = 1'b1;
            end
          end
          default: begin
            w_frame_err[v] = 1'b1;
          end
        endcase
      end else begin
        w_state_nxt[v] = r_state[v];
      end
    end
  end

  // Framing state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_state[v] <= ST_IDLE;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_state[v] <= w_state_nxt[v];
      end
    end
  end

  // Read/write pointers and occupancy per VC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_pop[v]) begin
          r_rd_ptr[v] <= ptr_inc(r_rd_ptr[v]);
        end
        if (w_push[v]) begin
          r_wr_ptr[v] <= ptr_inc(r_wr_ptr[v]);
        end
        if (w_push[v] && !w_pop[v]) begin
          r_count[v] <= r_count[v] + CNTW'(1);
        end else if (w_pop[v] && !w_push[v]) begin
          r_count[v] <= r_count[v] - CNTW'(1);
        end else begin
          r_count[v] <= r_count[v];
        end
      end
    end
  end

  // Credit pulses and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit <= '0;
      r_ovf    <= '0;
      r_pkt    <= '0;
    end else begin
      r_credit <= w_pop;
      r_ovf    <= r_ovf | w_drop;
      r_pkt    <= r_pkt | w_frame_err;
    end
  end

  // Flit storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_push[v]) begin
        r_mem[v][r_wr_ptr[v]] <= RX;
      end
    end
  end

  // Head flit of every VC presented with zero latency.
  always_comb begin
    Data_out = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      Data_out[v*DATA_WIDTH +: DATA_WIDTH] = r_mem[v][r_rd_ptr[v]];
    end
  end

  assign empty_out    = w_empty;
  assign full_out     = w_full;
  assign credit_out   = r_credit;
  assign overflow_err = r_ovf;
  assign pkt_err      = r_pkt;

  fifo_credit_based_vc_chk #(
    .NUM_VC (NUM_VC)
  ) u_chk (
    .clk          (clk),
    .reset        (reset),
    .empty_out    (w_empty),
    .full_out     (w_full),
    .credit_out   (r_credit),
    .pop          (w_pop),
    .overflow_err (r_ovf),
    .pkt_err      (r_pkt)
  );

endmodule

// Invariant checker for the VC buffer; holds no design state.
module fifo_credit_based_vc_chk #(
  parameter int NUM_VC = 2
) (
  input logic              clk,
  input logic              reset,
  input logic [NUM_VC-1:0] empty_out,
  input logic [NUM_VC-1:0] full_out,
  input logic [NUM_VC-1:0] credit_out,
  input logic [NUM_VC-1:0] pop,
  input logic [NUM_VC-1:0] overflow_err,
  input logic [NUM_VC-1:0] pkt_err
);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    a_not_empty_and_full: assert property (@(posedge clk) disable iff (!reset)
      !(empty_out[v] && full_out[v]));
    a_credit_follows_pop: assert property (@(posedge clk) disable iff (!reset)
      credit_out[v] |-> $past(pop[v]));
    a_ovf_sticky: assert property (@(posedge clk) disable iff (!reset)
      $past(overflow_err[v]) |-> overflow_err[v]);
    a_pkt_sticky: assert property (@(posedge clk) disable iff (!reset)
      $past(pkt_err[v]) |-> pkt_err[v]);
  end

endmodule

// File: tb/tb_fifo_credit_based_vc.sv
// Bench for fifo_credit_based_vc: two instances (depth 4 and depth 3) share one stimulus
// stream and are compared every cycle against a queue-based model of the VC buffer.
module tb_fifo_credit_based_vc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rx = 32'd0;
  logic        valid_in = 1'b0;
  logic        vc_in = 1'b0;
  logic [9:0]  read_en = 10'd0;

  logic [1:0]  w_credit [2];
  logic [1:0]  w_empty  [2];
  logic [1:0]  w_full   [2];
  logic [1:0]  w_ovf    [2];
  logic [1:0]  w_pkt    [2];
  logic [63:0] w_data   [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one queue per instance/VC plus the flags the spec defines.
  logic [31:0] mq [2][2][$];
  bit m_credit [2][2];
  bit m_ovf    [2][2];
  bit m_pkt    [2][2];
  bit m_inpkt  [2][2];

  bit chk_en = 1'b0;
  bit cnt_en = 1'b0;
  int cnt0 = 0;
  int cnt1 = 0;
  logic [1:0] e_emp, e_full, e_cr, e_ovf, e_pkt;

  always #5 clk = ~clk;

  fifo_credit_based_vc #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .NUM_VC(2), .NUM_OUT(5)) u_dut4 (
    .clk(clk), .reset(rst_n), .RX(rx), .valid_in(valid_in), .vc_in(vc_in), .read_en(read_en),
    .credit_out(w_credit[0]), .empty_out(w_empty[0]), .full_out(w_full[0]), .Data_out(w_data[0]),
    .overflow_err(w_ovf[0]), .pkt_err(w_pkt[0]));

  fifo_credit_based_vc #(.DATA_WIDTH(32), .FIFO_DEPTH(3), .NUM_VC(2), .NUM_OUT(5)) u_dut3 (
    .clk(clk), .reset(rst_n), .RX(rx), .valid_in(valid_in), .vc_in(vc_in), .read_en(read_en),
    .credit_out(w_credit[1]), .empty_out(w_empty[1]), .full_out(w_full[1]), .Data_out(w_data[1]),
    .overflow_err(w_ovf[1]), .pkt_err(w_pkt[1]));

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < 2; v++) begin
        mq[i][v].delete();
        m_credit[i][v] = 1'b0;
        m_ovf[i][v]    = 1'b0;
        m_pkt[i][v]    = 1'b0;
        m_inpkt[i][v]  = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < 2; v++) begin
        bit pop, wr, acc;
        logic [2:0] ty;
        pop = (read_en[v*5 +: 5] != 5'd0) && (mq[i][v].size() > 0);
        wr  = valid_in && (int'(vc_in) == v);
        acc = wr && ((mq[i][v].size() < depth_of(i)) || pop);
        if (wr && !acc) m_ovf[i][v] = 1'b1;
        if (acc) begin
          ty = rx[31:29];
          case (ty)
            3'b001: if (m_inpkt[i][v]) m_pkt[i][v] = 1'b1; else m_inpkt[i][v] = 1'b1;
            3'b010: if (!m_inpkt[i][v]) m_pkt[i][v] = 1'b1;
            3'b100: if (m_inpkt[i][v]) m_inpkt[i][v] = 1'b0; else m_pkt[i][v] = 1'b1;
            default: m_pkt[i][v] = 1'b1;
          endcase
        end
        if (pop) void'(mq[i][v].pop_front());
        if (acc) mq[i][v].push_back(rx);
        m_credit[i][v] = pop;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic v, input logic vc, input logic [31:0] d, input logic [9:0] rd);
    valid_in = v;
    vc_in    = vc;
    rx       = d;
    read_en  = rd;
    tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    read_en  = 10'd0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        for (int v = 0; v < 2; v++) begin
          e_emp[v]  = (mq[i][v].size() == 0);
          e_full[v] = (mq[i][v].size() == depth_of(i));
          e_cr[v]   = m_credit[i][v];
          e_ovf[v]  = m_ovf[i][v];
          e_pkt[v]  = m_pkt[i][v];
        end
        check($sformatf("u%0d empty_out", i), 64'(w_empty[i]), 64'(e_emp));
        check($sformatf("u%0d full_out", i), 64'(w_full[i]), 64'(e_full));
        check($sformatf("u%0d credit_out", i), 64'(w_credit[i]), 64'(e_cr));
        check($sformatf("u%0d overflow_err", i), 64'(w_ovf[i]), 64'(e_ovf));
        check($sformatf("u%0d pkt_err", i), 64'(w_pkt[i]), 64'(e_pkt));
        for (int v = 0; v < 2; v++) begin
          if (mq[i][v].size() > 0)
            check($sformatf("u%0d Data_out vc%0d", i, v), 64'(w_data[i][v*32 +: 32]), 64'(mq[i][v][0]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cnt_en && w_credit[0][0]) cnt0++;
    if (cnt_en && w_credit[1][0]) cnt1++;
  end

  initial begin
    logic [31:0] d;
    logic [2:0]  ty;
    logic [9:0]  rd;
    int          rprob;
    int          sel;

    model_reset();
    tick();
    tick();
    chk_en = 1'b1;
    check("reset empty_out", 64'(w_empty[0]), 64'(2'b11));
    check("reset full_out", 64'(w_full[0]), 64'(2'b00));
    check("reset credit_out", 64'(w_credit[0]), 64'(2'b00));
    check("reset overflow_err", 64'(w_ovf[0]), 64'(2'b00));
    check("reset pkt_err", 64'(w_pkt[0]), 64'(2'b00));
    rst_n = 1'b1;

    // One well-formed packet fills VC1 of the depth-4 instance.
    cyc(1'b1, 1'b1, 32'h2000_0001, 10'd0);
    cyc(1'b1, 1'b1, 32'h4000_0002, 10'd0);
    cyc(1'b1, 1'b1, 32'h4000_0003, 10'd0);
    cyc(1'b1, 1'b1, 32'h8000_0004, 10'd0);
    check("fill full_out", 64'(w_full[0]), 64'(2'b10));
    check("fill pkt_err", 64'(w_pkt[0]), 64'(2'b00));
    check("fill head vc1", 64'(w_data[0][63:32]), 64'(32'h2000_0001));

    // Full VC with a same-cycle pop accepts, then without a pop drops.
    cyc(1'b1, 1'b1, 32'h2000_0005, 10'b00_0010_0000);
    check("full+pop full_out", 64'(w_full[0]), 64'(2'b10));
    check("full+pop credit_out", 64'(w_credit[0]), 64'(2'b10));
    check("full+pop overflow_err", 64'(w_ovf[0]), 64'(2'b00));
    check("full+pop head vc1", 64'(w_data[0][63:32]), 64'(32'h4000_0002));
    cyc(1'b1, 1'b1, 32'h4000_0006, 10'd0);
    check("full drop overflow_err", 64'(w_ovf[0]), 64'(2'b10));
    check("full drop credit_out", 64'(w_credit[0]), 64'(2'b00));
    check("full drop head vc1", 64'(w_data[0][63:32]), 64'(32'h4000_0002));
    check("full drop pkt_err", 64'(w_pkt[0]), 64'(2'b00));

    // Reset with VC1 still full discards everything.
    cyc(1'b0, 1'b0, 32'd0, 10'd0);
    do_reset();
    check("midreset overflow_err", 64'(w_ovf[0]), 64'(2'b00));
    check("midreset empty_out", 64'(w_empty[0]), 64'(2'b11));

    // Six fill/drain rounds of 3 flits on VC0: pointer wrap on the depth-3 queue.
    cnt_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      cyc(1'b1, 1'b0, {3'b001, 29'(r * 16 + 1)}, {5'($urandom), 5'd0});
      cyc(1'b1, 1'b0, {3'b010, 29'(r * 16 + 2)}, {5'($urandom), 5'd0});
      cyc(1'b1, 1'b0, {3'b100, 29'(r * 16 + 3)}, {5'($urandom), 5'd0});
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, $urandom, {5'd0, 5'($urandom_range(1, 31))});
    end
    cyc(1'b0, 1'b0, 32'd0, 10'd0);
    cnt_en = 1'b0;
    check("depth3 credit pulses", 64'(cnt1), 64'(18));
    check("depth4 credit pulses", 64'(cnt0), 64'(18));

    // Body into an idle VC flags a framing error but is still stored.
    cyc(1'b1, 1'b0, 32'h4000_0010, 10'd0);
    check("body-idle pkt_err", 64'(w_pkt[0]), 64'(2'b01));
    check("body-idle empty_out", 64'(w_empty[0]), 64'(2'b10));
    check("body-idle head vc0", 64'(w_data[0][31:0]), 64'(32'h4000_0010));
    cyc(1'b1, 1'b0, 32'h2000_0011, 10'd0);
    cyc(1'b0, 1'b0, 32'd0, 10'b00000_00001);
    cyc(1'b0, 1'b0, 32'd0, 10'b00000_00001);
    cyc(1'b0, 1'b0, 32'd0, 10'b00000_01001);
    check("empty read credit_out", 64'(w_credit[0]), 64'(2'b00));
    check("empty read empty_out", 64'(w_empty[0]), 64'(2'b11));
    cyc(1'b1, 1'b0, 32'h8000_0012, 10'd0);
    cyc(1'b0, 1'b0, 32'd0, 10'b00000_01001);
    check("dual-bit pop empty_out", 64'(w_empty[0]), 64'(2'b11));
    check("dual-bit pop credit_out", 64'(w_credit[0]), 64'(2'b01));
    cyc(1'b0, 1'b0, 32'd0, 10'd0);
    check("single credit pulse", 64'(w_credit[0]), 64'(2'b00));
    check("tail in pkt pkt_err", 64'(w_pkt[0]), 64'(2'b01));

    // Randomized traffic with occasional resets to re-arm the sticky flags.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        rprob = (n < 1500) ? 25 : 60;
        sel = int'($urandom_range(0, 19));
        if (sel < 5)       ty = 3'b001;
        else if (sel < 13) ty = 3'b010;
        else if (sel < 18) ty = 3'b100;
        else               ty = 3'($urandom);
        d = {ty, 29'($urandom)};
        rd = 10'd0;
        if (int'($urandom_range(0, 99)) < rprob) rd[4:0] = 5'($urandom_range(1, 31));
        if (int'($urandom_range(0, 99)) < rprob) rd[9:5] = 5'($urandom_range(1, 31));
        cyc($urandom_range(0, 3) != 0, 1'($urandom), d, rd);
      end
    end
    cyc(1'b0, 1'b0, 32'd0, 10'd0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_credit_based_vc.md
Name: fifo_credit_based_vc

Overview:
- Parametrised input-port buffer for the credit-based router. Successor to the single-queue FIFO_credit_based.
- Holds NUM_VC independent virtual-channel queues of FIFO_DEPTH flits each, filled from one link.
- Accepts per-VC read enables from NUM_OUT output arbiters and returns one credit per VC per flit read.
- Adds a per-VC packet-framing checker and sticky error flags, which the single-queue FIFO lacks.

Parameters:
DATA_WIDTH, 32, flit width; flit type in bits [DATA_WIDTH-1:DATA_WIDTH-3] (001 header, 010 body, 100 tail)
FIFO_DEPTH, 4, flits per VC queue; any value >= 2, not restricted to powers of two
NUM_VC, 2, number of virtual channels, >= 1
NUM_OUT, 5, number of read-enable sources per VC (router output ports)
VCW, clog2(NUM_VC) min 1, VC index width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
RX  input  DATA_WIDTH  incoming flit
valid_in  input  1  RX valid this cycle
vc_in  input  VCW  target VC of RX
read_en  input  NUM_VC*NUM_OUT  bit v*NUM_OUT+k = output k pops head of VC v
credit_out  output  NUM_VC  one-cycle credit pulse per VC
empty_out  output  NUM_VC  VC queue empty
full_out  output  NUM_VC  VC queue holds FIFO_DEPTH flits
Data_out  output  NUM_VC*DATA_WIDTH  head flit of VC v at slice v (first-word fall-through)
overflow_err  output  NUM_VC  sticky: write attempted into a full VC
pkt_err  output  NUM_VC  sticky: framing violation on VC

Behaviour:
- Reset (reset=0, asynchronous): pointers and counts = 0; credit_out = 0; overflow_err = 0; pkt_err = 0; every framing state = IDLE; empty_out = all 1s; full_out = 0.
- Storage contents are not reset. Data_out of an empty VC is don't-care.
- Per-VC state: rd_ptr, wr_ptr (wrap at FIFO_DEPTH-1 -> 0), count 0..FIFO_DEPTH.
- empty_out[v] = (count==0) and full_out[v] = (count==FIFO_DEPTH), both combinational from registered count.
- Data_out slice v = mem[v][rd_ptr[v]], combinational; zero latency from head to output.
- Read on VC v: OR of its NUM_OUT read_en bits AND not empty. Multiple bits set counts as one pop. read_en on an empty VC is ignored; no credit is issued.
- Write: valid_in AND vc_in<NUM_VC. Out-of-range vc_in is ignored with no flag.
- Write accepted if count<FIFO_DEPTH, or if the VC is full and a read pops the same VC the same cycle (count stays FIFO_DEPTH).
- Write into a full VC with no same-cycle read is dropped and sets overflow_err[v].
- Write to an empty VC: flit appears on Data_out the next cycle; it cannot be popped in the write cycle.
- Simultaneous read and write on one VC: count unchanged. On different VCs: each count updates independently.
- credit_out[v] registered: 1 in the cycle after each accepted pop on v, otherwise 0. Back-to-back pops give a continuous high pulse.
- Framing FSM per VC (IDLE, IN_PKT), advanced only by accepted writes on that VC:
  - IDLE + header -> IN_PKT.
  - IN_PKT + body -> IN_PKT.
  - IN_PKT + tail -> IDLE.
  - IDLE + body/tail -> pkt_err set, stay IDLE.
  - IN_PKT + header -> pkt_err set, stay IN_PKT.
  - Any other type code -> pkt_err set, no transition.
  - Flits are stored regardless of framing errors.
- Dropped writes do not advance the FSM.
- Sticky flags clear only on reset.
- Reset asserted mid-packet or mid-transfer: all queues discarded, credits not returned. The upstream credit counter is reset by the same reset.

Test Plan:
- Reset, NUM_VC=2, FIFO_DEPTH=4 -> empty_out=2'b11, full_out=0, credit_out=0, errors=0.
- Write 4 flits (header 0x2000_0001, body x2, tail 0x8000_0004) to VC1; no reads -> full_out=2'b10, pkt_err=0; Data_out[63:32]=0x2000_0001.
- VC1 full, valid_in to VC1 with read_en bit 5 high -> write accepted, count stays 4, credit_out[1]=1 next cycle, overflow_err=0. Repeat without read -> overflow_err[1]=1, flit dropped.
- Fill and drain VC0 six times with FIFO_DEPTH=3 -> pointers wrap; flits exit in order; exactly 18 credit_out[0] pulses.
- Body flit to IDLE VC0 -> pkt_err[0]=1, flit stored, pkt_err[1]=0; then header to VC0 -> FSM enters IN_PKT.
- read_en bits 0 and 3 high together on empty VC0, then on a 1-flit VC0 -> first: no pop, no credit; second: one pop, one credit pulse, empty_out[0]=1.
